// File: rtl/nibble_serial_adder.sv
// Wide adder that walks N-nibble operands through a single 4-bit carry-lookahead
// slice, one nibble per clock, LSB first, under a start/done handshake.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out,
  output logic                   overflow
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [W-1:0]       a_reg, a_next;
  logic [W-1:0]       b_reg, b_next;
  logic               carry_reg, carry_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               c_out_reg, c_out_next;
  logic               overflow_reg, overflow_next;
  logic [3:0]         sum_nib_reg  [NIBBLES];
  logic [3:0]         sum_nib_next [NIBBLES];

  logic [3:0]         a_nib [NIBBLES];
  logic [3:0]         b_nib [NIBBLES];

  // Nibble views of the captured operands and of the result register.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign a_nib[gi]          = a_reg[4*gi +: 4];
    assign b_nib[gi]          = b_reg[4*gi +: 4];
    assign sum[4*gi +: 4]     = sum_nib_reg[gi];
  end

  // 4-bit carry-lookahead slice
  logic [3:0] slice_a, slice_b, g, p, slice_sum;
  logic [4:0] c;

  assign slice_a = a_nib[idx_reg];
  assign slice_b = b_nib[idx_reg];
  assign g       = slice_a & slice_b;
  assign p       = slice_a ^ slice_b;
  assign c[0]    = carry_reg;
  assign c[1]    = g[0] | (p[0] & c[0]);
  assign c[2]    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3]    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & c[0]);
  assign c[4]    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  for (genvar gi = 0; gi < 4; gi++) begin : g_slice_sum
    assign slice_sum[gi] = p[gi] ^ c[gi];
  end

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    carry_next    = carry_reg;
    idx_next      = idx_reg;
    c_out_next    = c_out_reg;
    overflow_next = overflow_reg;
    sum_nib_next  = sum_nib_reg;

    unique case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          a_next        = a;
          b_next        = b;
          carry_next    = c_in;
          idx_next      = '0;
          c_out_next    = 1'b0;
          overflow_next = 1'b0;
          for (int i = 0; i < NIBBLES; i++) sum_nib_next[i] = '0;
          state_next    = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        sum_nib_next[idx_reg] = slice_sum;
        carry_next            = c[4];
        if (idx_reg == LAST_IDX) begin
          // c3/c4 of the top nibble are the carries into and out of bit W-1.
          c_out_next    = c[4];
          overflow_next = c[3] ^ c[4];
          state_next    = DONE;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
      idx_reg      <= '0;
      c_out_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      for (int i = 0; i < NIBBLES; i++) sum_nib_reg[i] <= '0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      carry_reg    <= carry_next;
      idx_reg      <= idx_next;
      c_out_reg    <= c_out_next;
      overflow_reg <= overflow_next;
      for (int i = 0; i < NIBBLES; i++) sum_nib_reg[i] <= sum_nib_next[i];
    end
  end

  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign c_out    = c_out_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES=4): directed vectors push
// expected results; a negedge monitor pops and compares on every done pulse.
module tb_nibble_serial_adder;

  logic        clock = 1'b0;
  logic        reset, start, c_in;
  logic [15:0] a, b;
  logic        busy, done, c_out, overflow;
  logic [15:0] sum;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb[$];

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum),
    .c_out(c_out), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
    else $display("check %s: %0h ok", name, act);
  endtask

  // Monitor: one line per completed transaction.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      done_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got sum=%0h expected no result", sum);
      end else begin
        e = sb.pop_front();
        $display("txn done: sum=%0h c_out=%0b overflow=%0b", sum, c_out, overflow);
        chk("sum", 32'(sum), 32'(e.s));
        chk("c_out", 32'(c_out), 32'(e.co));
        chk("overflow", 32'(overflow), 32'(e.ov));
      end
    end
  end

  task automatic wait_done(input string tag, output int lat, output int bc);
    bit seen;
    lat = 0;
    bc = 0;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clock);
      lat++;
      if (busy) bc++;
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 50 cycles", tag);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic [15:0] es, input logic eco,
                        input logic eov);
    int lat, bc;
    @(posedge clock); #1;
    a = av; b = bv; c_in = cv; start = 1'b1;
    sb.push_back('{es, eco, eov});
    @(posedge clock); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
    wait_done(tag, lat, bc);
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd4);
    @(negedge clock);
    chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, d0, cyc, nd, last;
    bit busy_bad;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    run_op("basic",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("wrap_b",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("wrap_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("neg_ovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("alt",      16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Second start during RUN must be ignored.
    d0 = done_count;
    @(posedge clock); #1;
    a = 16'h0F0F; b = 16'h00F1; c_in = 1'b0; start = 1'b1;
    sb.push_back('{16'h1000, 1'b0, 1'b0});
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("ignore", lat, bc);
    repeat (8) @(negedge clock);
    chk("ignore_done_count", 32'(done_count - d0), 32'd1);

    // Reset in the second RUN cycle discards the operation.
    @(posedge clock); #1;
    a = 16'h1234; b = 16'h1111; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // start held high: back-to-back results every 5 cycles.
    repeat (3) sb.push_back('{16'h3333, 1'b0, 1'b0});
    @(posedge clock); #1;
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; start = 1'b1;
    @(posedge clock);
    cyc = 0; nd = 0; last = 0; busy_bad = 0;
    for (int k = 0; k < 60 && nd < 3; k++) begin
      @(negedge clock);
      cyc++;
      if (busy == done) busy_bad = 1;
      if (done) begin
        nd++;
        chk("stream_period", 32'(cyc - last), 32'd5);
        last = cyc;
        if (nd == 3) start = 1'b0;
      end
    end
    chk("stream_done_count", 32'(nd), 32'd3);
    chk("stream_busy_shape", 32'(busy_bad), 32'd0);

    repeat (8) @(negedge clock);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
